// File: rtl/image_classify_sequencer.sv
// image_classify_sequencer
//   Steps through NUM_IMAGES images stored back-to-back in image memory. For
//   each image it drives the base address, waits SETTLE_CYCLES for the
//   combinational network, captures the class scores, runs a one-class-per-cycle
//   argmax and offers the winner on a valid/ready port.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           begin a pass (honoured only in IDLE or DONE)
//   abort           return to IDLE from any state
//   loop_mode       wrap to image 0 after the last image (sampled at handshake)
//   mem_addr        registered image base address to the memory reader
//   scores          NUM_CLASSES packed scores, class k at [k*SCORE_W +: SCORE_W]
//   res_valid/res_ready   result handshake
//   res_class, res_score, res_index   winning class, its score, image number
//   busy            a pass is in progress (not IDLE, not DONE)
//   done            pass finished, sitting in DONE
module image_classify_sequencer #(
    parameter int unsigned IN_WIDTH      = 784,
    parameter int unsigned NUM_CLASSES   = 10,
    parameter int unsigned SCORE_W       = 8,
    parameter bit          SIGNED_SCORES = 1'b0,
    parameter int unsigned NUM_IMAGES    = 4,
    parameter int unsigned BASE_ADDR     = 0,
    parameter int unsigned SETTLE_CYCLES = 4,
    localparam int CW = $clog2(NUM_CLASSES),
    localparam int IW = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           loop_mode,
    output logic [31:0]                    mem_addr,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [CW-1:0]                  res_class,
    output logic [SCORE_W-1:0]             res_score,
    output logic [IW-1:0]                  res_index,
    output logic                           busy,
    output logic                           done
);

    // k runs one past the last class: that extra cycle publishes the result
    localparam int KW = $clog2(NUM_CLASSES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ARGMAX,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t               state;
    logic [IW-1:0]        img_idx;
    logic [SW-1:0]        settle_cnt;
    logic [KW-1:0]        k;
    logic [SCORE_W-1:0]   cap [NUM_CLASSES];
    logic [SCORE_W-1:0]   best;
    logic [CW-1:0]        best_idx;
    logic [SCORE_W-1:0]   cur;
    logic                 gt;

    // Candidate for this argmax step; strict greater keeps the lowest index on ties
    always_comb begin
        cur = cap[k[CW-1:0]];
        if (SIGNED_SCORES)
            gt = $signed(cur) > $signed(best);
        else
            gt = cur > best;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            img_idx    <= '0;
            settle_cnt <= '0;
            k          <= '0;
            best       <= '0;
            best_idx   <= '0;
            for (int c = 0; c < int'(NUM_CLASSES); c++)
                cap[c] <= '0;
            mem_addr   <= 32'(BASE_ADDR);
            res_valid  <= 1'b0;
            res_class  <= '0;
            res_score  <= '0;
            res_index  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort) begin
            // address and result registers deliberately hold their values
            state     <= S_IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        img_idx    <= '0;
                        mem_addr   <= 32'(BASE_ADDR);
                        settle_cnt <= SW'(SETTLE_CYCLES);
                        state      <= S_SETTLE;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end

                S_SETTLE: begin
                    settle_cnt <= settle_cnt - 1'b1;
                    if (settle_cnt == SW'(1)) begin
                        for (int c = 0; c < int'(NUM_CLASSES); c++)
                            cap[c] <= scores[c*SCORE_W +: SCORE_W];
                        best     <= scores[SCORE_W-1:0];
                        best_idx <= '0;
                        k        <= KW'(1);
                        state    <= S_ARGMAX;
                    end
                end

                S_ARGMAX: begin
                    if (k == KW'(NUM_CLASSES)) begin
                        // best/best_idx already include the last class here
                        res_class <= best_idx;
                        res_score <= best;
                        res_index <= img_idx;
                        res_valid <= 1'b1;
                        state     <= S_OUTPUT;
                    end else begin
                        if (gt) begin
                            best     <= cur;
                            best_idx <= k[CW-1:0];
                        end
                        k <= k + 1'b1;
                    end
                end

                S_OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (img_idx != IW'(NUM_IMAGES - 1)) begin
                            img_idx    <= img_idx + 1'b1;
                            mem_addr   <= mem_addr + 32'(IN_WIDTH);
                            settle_cnt <= SW'(SETTLE_CYCLES);
                            state      <= S_SETTLE;
                        end else if (loop_mode) begin
                            img_idx    <= '0;
                            mem_addr   <= 32'(BASE_ADDR);
                            settle_cnt <= SW'(SETTLE_CYCLES);
                            state      <= S_SETTLE;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
